// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle control unit: FSM states, opcodes,
// R-type function codes, ALU operations, next-PC and write-register selects,
// and the instruction classes produced by mc_decode.
package mc_pkg;

  typedef enum logic [2:0] {
    StIf   = 3'b000,
    StId   = 3'b001,
    StExe  = 3'b010,
    StMem  = 3'b011,
    StWb   = 3'b100,
    StHalt = 3'b111
  } state_e;

  // Opcodes
  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpSlti  = 6'b001010;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpJal   = 6'b000011;
  localparam logic [5:0] OpHalt  = 6'b111111;

  // R-type function codes
  localparam logic [5:0] FnAdd = 6'b100000;
  localparam logic [5:0] FnSub = 6'b100010;
  localparam logic [5:0] FnAnd = 6'b100100;
  localparam logic [5:0] FnOr  = 6'b100101;
  localparam logic [5:0] FnSlt = 6'b101010;
  localparam logic [5:0] FnSll = 6'b000000;
  localparam logic [5:0] FnJr  = 6'b001000;

  // ALU operations
  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] AluAnd = 3'b010;
  localparam logic [2:0] AluOr  = 3'b011;
  localparam logic [2:0] AluSll = 3'b100;
  localparam logic [2:0] AluSlt = 3'b101;

  // Next-PC select
  localparam logic [1:0] PcSelPc4 = 2'b00;
  localparam logic [1:0] PcSelBr  = 2'b01;
  localparam logic [1:0] PcSelJmp = 2'b10;
  localparam logic [1:0] PcSelRs  = 2'b11;

  // Write-register select
  localparam logic [1:0] RegDstRt = 2'b00;
  localparam logic [1:0] RegDstRd = 2'b01;
  localparam logic [1:0] RegDst31 = 2'b10;

  // Instruction classes; each class has a fixed state path through the FSM
  typedef enum logic [3:0] {
    ClsRAlu    = 4'd0,
    ClsIAlu    = 4'd1,
    ClsLw      = 4'd2,
    ClsSw      = 4'd3,
    ClsBeq     = 4'd4,
    ClsBne     = 4'd5,
    ClsJ       = 4'd6,
    ClsJal     = 4'd7,
    ClsJr      = 4'd8,
    ClsHalt    = 4'd9,
    ClsIllegal = 4'd10
  } cls_e;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction decoder: op/func to instruction class, ALU
// operation, operand selects, sign-extend enable and an illegal flag.
// ALUSrcA=1 selects the shift amount (sll); ALUSrcB=1 selects the immediate.
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] i_op,
  input  logic [5:0] i_func,
  output logic [3:0] o_cls,
  output logic [2:0] o_aluop,
  output logic       o_alu_src_a,
  output logic       o_alu_src_b,
  output logic       o_ext_sel,
  output logic       o_illegal
);

  // Decode table; anything not listed falls through as illegal
  always_comb begin
    o_cls       = ClsIllegal;
    o_aluop     = AluAdd;
    o_alu_src_a = 1'b0;
    o_alu_src_b = 1'b0;
    o_ext_sel   = 1'b0;
    case (i_op)
      OpRtype: begin
        case (i_func)
          FnAdd: begin o_cls = ClsRAlu; o_aluop = AluAdd; end
          FnSub: begin o_cls = ClsRAlu; o_aluop = AluSub; end
          FnAnd: begin o_cls = ClsRAlu; o_aluop = AluAnd; end
          FnOr:  begin o_cls = ClsRAlu; o_aluop = AluOr;  end
          FnSlt: begin o_cls = ClsRAlu; o_aluop = AluSlt; end
          FnSll: begin o_cls = ClsRAlu; o_aluop = AluSll; o_alu_src_a = 1'b1; end
          FnJr:  o_cls = ClsJr;
          default: o_cls = ClsIllegal;
        endcase
      end
      OpAddi: begin
        o_cls = ClsIAlu; o_aluop = AluAdd; o_alu_src_b = 1'b1; o_ext_sel = 1'b1;
      end
      OpOri: begin
        o_cls = ClsIAlu; o_aluop = AluOr; o_alu_src_b = 1'b1;
      end
      OpSlti: begin
        o_cls = ClsIAlu; o_aluop = AluSlt; o_alu_src_b = 1'b1; o_ext_sel = 1'b1;
      end
      OpLw: begin
        o_cls = ClsLw; o_aluop = AluAdd; o_alu_src_b = 1'b1; o_ext_sel = 1'b1;
      end
      OpSw: begin
        o_cls = ClsSw; o_aluop = AluAdd; o_alu_src_b = 1'b1; o_ext_sel = 1'b1;
      end
      OpBeq: begin o_cls = ClsBeq; o_aluop = AluSub; o_ext_sel = 1'b1; end
      OpBne: begin o_cls = ClsBne; o_aluop = AluSub; o_ext_sel = 1'b1; end
      OpJ:    o_cls = ClsJ;
      OpJal:  o_cls = ClsJal;
      OpHalt: o_cls = ClsHalt;
      default: o_cls = ClsIllegal;
    endcase
  end

  assign o_illegal = (o_cls == ClsIllegal);

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle control unit: IF/ID/EXE/MEM/WB state machine with a MEM wait
// counter, sticky illegal flag and a free-running cycle counter.
// Optional feature: define MC_CTRL_STEP_EN to add the `step` port; the FSM
// and counters then advance only on edges where step=1, and write enables
// are gated by step so each write happens once per step.
module mc_ctrl
  import mc_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 0,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             nRST,
`ifdef MC_CTRL_STEP_EN
  input  logic             step,
`endif
  input  logic [5:0]       op,
  input  logic [5:0]       func,
  input  logic             zero,
  output logic             PCWre,
  output logic             IRWre,
  output logic             RegWr,
  output logic [1:0]       RegDst,
  output logic             DB,
  output logic             nRD,
  output logic             nWR,
  output logic [1:0]       PCSel,
  output logic [2:0]       ALUop,
  output logic             ALUSrcA,
  output logic             ALUSrcB,
  output logic             ExtSel,
  output logic [2:0]       state,
  output logic             instr_done,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] cyc_cnt
);

  state_e           r_state;
  logic [3:0]       r_wait;
  logic             r_illegal;
  logic [CNT_W-1:0] r_cyc_cnt;

  state_e     w_next;
  logic [3:0] w_cls;
  logic       w_dec_illegal;
  logic       w_adv;
  logic       w_gate;
  logic       w_mem_last;
  logic       w_pc_wre;
  logic       w_reg_wr;
  logic       w_ir_wre;
  logic       w_rd;
  logic       w_wr;
  logic       w_db;
  logic       w_halt_entry;
  logic [1:0] w_reg_dst;
  logic [1:0] w_pc_sel;

`ifdef MC_CTRL_STEP_EN
  assign w_adv = step;
`else
  assign w_adv = 1'b1;
`endif

  // Write enables drop while in reset and, in step mode, between steps
  assign w_gate     = nRST & w_adv;
  assign w_mem_last = (r_wait == 4'(MEM_WAIT));

  mc_decode u_decode (
    .i_op        (op),
    .i_func      (func),
    .o_cls       (w_cls),
    .o_aluop     (ALUop),
    .o_alu_src_a (ALUSrcA),
    .o_alu_src_b (ALUSrcB),
    .o_ext_sel   (ExtSel),
    .o_illegal   (w_dec_illegal)
  );

  // Next state and raw (ungated) control outputs from state, class and zero
  always_comb begin
    w_next       = r_state;
    w_pc_wre     = 1'b0;
    w_reg_wr     = 1'b0;
    w_ir_wre     = 1'b0;
    w_rd         = 1'b0;
    w_wr         = 1'b0;
    w_db         = 1'b0;
    w_halt_entry = 1'b0;
    w_reg_dst    = RegDstRt;
    w_pc_sel     = PcSelPc4;
    case (r_state)
      StIf: begin
        w_ir_wre = 1'b1;
        w_next   = StId;
      end
      StId: begin
        case (w_cls)
          ClsJ: begin
            w_pc_sel = PcSelJmp; w_pc_wre = 1'b1; w_next = StIf;
          end
          ClsJal: begin
            w_pc_sel  = PcSelJmp; w_pc_wre = 1'b1; w_next = StIf;
            w_reg_wr  = 1'b1;
            w_reg_dst = RegDst31;
          end
          ClsJr: begin
            w_pc_sel = PcSelRs; w_pc_wre = 1'b1; w_next = StIf;
          end
          ClsHalt: begin
            w_halt_entry = 1'b1; w_next = StHalt;
          end
          ClsIllegal: begin
            w_pc_wre = 1'b1; w_next = StIf;
          end
          default: w_next = StExe;
        endcase
      end
      StExe: begin
        case (w_cls)
          ClsBeq: begin
            w_pc_sel = zero ? PcSelBr : PcSelPc4; w_pc_wre = 1'b1; w_next = StIf;
          end
          ClsBne: begin
            w_pc_sel = zero ? PcSelPc4 : PcSelBr; w_pc_wre = 1'b1; w_next = StIf;
          end
          ClsLw, ClsSw: w_next = StMem;
          default:      w_next = StWb;
        endcase
      end
      StMem: begin
        w_rd = (w_cls == ClsLw);
        // Write strobe only in the final MEM cycle so the RAM sees one write
        w_wr = (w_cls == ClsSw) && w_mem_last;
        if (w_mem_last) begin
          if (w_cls == ClsSw) begin
            w_pc_wre = 1'b1;
            w_next   = StIf;
          end else begin
            w_next = StWb;
          end
        end
      end
      StWb: begin
        w_reg_wr  = 1'b1;
        w_db      = (w_cls == ClsLw);
        w_reg_dst = (w_cls == ClsRAlu) ? RegDstRd : RegDstRt;
        w_pc_wre  = 1'b1;
        w_next    = StIf;
      end
      StHalt:  w_next = StHalt;
      default: w_next = StIf;
    endcase
  end

  assign PCWre      = w_pc_wre & w_gate;
  assign RegWr      = w_reg_wr & w_gate;
  assign IRWre      = w_ir_wre & w_gate;
  assign nWR        = ~(w_wr & w_gate);
  assign nRD        = ~(w_rd & nRST);
  assign DB         = w_db;
  assign RegDst     = w_reg_dst;
  assign PCSel      = w_pc_sel;
  assign instr_done = (w_pc_wre | w_halt_entry) & w_gate;
  assign state      = r_state;
  assign halted     = (r_state == StHalt);
  assign illegal    = r_illegal;
  assign cyc_cnt    = r_cyc_cnt;

  // State, wait counter, illegal flag and cycle counter; reset overrides step
  always_ff @(posedge clk) begin
    if (!nRST) begin
      r_state   <= StIf;
      r_wait    <= 4'd0;
      r_illegal <= 1'b0;
      r_cyc_cnt <= '0;
    end else if (w_adv) begin
      r_state <= w_next;
      if (r_state == StMem && !w_mem_last) begin
        r_wait <= r_wait + 4'd1;
      end else begin
        r_wait <= 4'd0;
      end
      if (r_state == StId && w_dec_illegal) begin
        r_illegal <= 1'b1;
      end
      if (r_state != StHalt) begin
        r_cyc_cnt <= r_cyc_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl. Each instruction is expanded into the list
// of cycles it must take (from its class and MEM_WAIT), and every cycle's
// outputs are compared against that list. Works with or without
// MC_CTRL_STEP_EN; with it, step pulses once every 5 clocks.
module tb_mc_ctrl;

  localparam int unsigned MemWait = 3;
`ifdef MC_CTRL_STEP_EN
  localparam int StepGap = 4;
`else
  localparam int StepGap = 0;
`endif

  logic        clk = 1'b0;
  logic        nRST = 1'b0;
  logic [5:0]  op = '0;
  logic [5:0]  func = '0;
  logic        zero = 1'b0;
`ifdef MC_CTRL_STEP_EN
  logic        step = 1'b0;
`endif
  logic        PCWre, IRWre, RegWr, DB, nRD, nWR;
  logic [1:0]  RegDst, PCSel;
  logic [2:0]  ALUop;
  logic        ALUSrcA, ALUSrcB, ExtSel;
  logic [2:0]  state;
  logic        instr_done, halted, illegal;
  logic [15:0] cyc_cnt;

  mc_ctrl #(
    .MEM_WAIT (MemWait),
    .CNT_W    (16)
  ) dut (
    .clk        (clk),
    .nRST       (nRST),
`ifdef MC_CTRL_STEP_EN
    .step       (step),
`endif
    .op         (op),
    .func       (func),
    .zero       (zero),
    .PCWre      (PCWre),
    .IRWre      (IRWre),
    .RegWr      (RegWr),
    .RegDst     (RegDst),
    .DB         (DB),
    .nRD        (nRD),
    .nWR        (nWR),
    .PCSel      (PCSel),
    .ALUop      (ALUop),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ExtSel     (ExtSel),
    .state      (state),
    .instr_done (instr_done),
    .halted     (halted),
    .illegal    (illegal),
    .cyc_cnt    (cyc_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] st;
    bit         pcwre, regwr, irwre, nrd, nwr, done, db, chk_db, chk_alu, set_ill;
    logic [1:0] regdst, pcsel;
    logic [2:0] alu;
  } exp_t;

  exp_t  seq[$];
  int    n_pass = 0;
  int    n_total = 0;
  int    exp_cnt = 0;
  bit    exp_ill = 1'b0;
  string cur = "init";

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s/%s: got %0h expected %0h at %0t", cur, tag, got, exp, $time);
  endtask

  // 0 R-alu, 1 I-alu, 2 lw, 3 sw, 4 beq, 5 bne, 6 j, 7 jal, 8 jr, 9 halt, 10 illegal
  function automatic int cls_of(input logic [5:0] o, input logic [5:0] f);
    case (o)
      6'h00: begin
        if (f inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h00}) return 0;
        if (f == 6'h08) return 8;
        return 10;
      end
      6'h08, 6'h0d, 6'h0a: return 1;
      6'h23: return 2;
      6'h2b: return 3;
      6'h04: return 4;
      6'h05: return 5;
      6'h02: return 6;
      6'h03: return 7;
      6'h3f: return 9;
      default: return 10;
    endcase
  endfunction

  function automatic logic [2:0] alu_of(input logic [5:0] o, input logic [5:0] f);
    case (o)
      6'h00: case (f)
        6'h22: return 3'd1;
        6'h24: return 3'd2;
        6'h25: return 3'd3;
        6'h2a: return 3'd5;
        6'h00: return 3'd4;
        default: return 3'd0;
      endcase
      6'h0d: return 3'd3;
      6'h0a: return 3'd5;
      6'h04, 6'h05: return 3'd1;
      default: return 3'd0;
    endcase
  endfunction

  function automatic exp_t blank(input logic [2:0] st);
    exp_t e;
    e = '{st: st, pcwre: 0, regwr: 0, irwre: 0, nrd: 1, nwr: 1, done: 0, db: 0,
          chk_db: 0, chk_alu: 0, set_ill: 0, regdst: 2'd0, pcsel: 2'd0, alu: 3'd0};
    return e;
  endfunction

  // Expand one instruction into its expected cycles
  function automatic void build(input logic [5:0] o, input logic [5:0] f, input bit z);
    exp_t e;
    int   c;
    bit   last;
    c = cls_of(o, f);
    seq.delete();
    e = blank(3'd0); e.irwre = 1; seq.push_back(e);
    e = blank(3'd1);
    if (c inside {6, 7, 8, 10}) begin
      e.pcwre = 1; e.done = 1;
      e.pcsel = (c == 8) ? 2'd3 : (c == 10) ? 2'd0 : 2'd2;
      if (c == 7) begin e.regwr = 1; e.regdst = 2'd2; end
      if (c == 10) e.set_ill = 1;
      seq.push_back(e);
      return;
    end
    if (c == 9) begin e.done = 1; seq.push_back(e); return; end
    seq.push_back(e);
    e = blank(3'd2); e.chk_alu = 1; e.alu = alu_of(o, f);
    if (c == 4 || c == 5) begin
      e.pcwre = 1; e.done = 1;
      e.pcsel = (((c == 4) ? z : !z) != 0) ? 2'd1 : 2'd0;
      seq.push_back(e);
      return;
    end
    seq.push_back(e);
    if (c == 2 || c == 3) begin
      for (int k = 0; k <= int'(MemWait); k++) begin
        last = (k == int'(MemWait));
        e = blank(3'd3);
        e.nrd = (c == 2) ? 1'b0 : 1'b1;
        if (c == 3 && last) begin e.nwr = 0; e.pcwre = 1; e.done = 1; end
        seq.push_back(e);
      end
      if (c == 3) return;
    end
    e = blank(3'd4);
    e.regwr = 1; e.chk_db = 1; e.db = (c == 2); e.regdst = (c == 0) ? 2'd1 : 2'd0;
    e.pcwre = 1; e.done = 1; e.pcsel = 2'd0;
    seq.push_back(e);
  endfunction

  // Called at posedge+1; checks at the following negedge, returns at posedge+1
  task automatic cycle(input exp_t e, input bit adv);
`ifdef MC_CTRL_STEP_EN
    step = adv;
`endif
    @(negedge clk);
    check("state", 32'(state), 32'(e.st));
    check("PCWre", 32'(PCWre), 32'(adv & e.pcwre));
    check("RegWr", 32'(RegWr), 32'(adv & e.regwr));
    check("IRWre", 32'(IRWre), 32'(adv & e.irwre));
    check("nRD", 32'(nRD), 32'(e.nrd));
    check("nWR", 32'(nWR), 32'(adv ? e.nwr : 1'b1));
    check("instr_done", 32'(instr_done), 32'(adv & e.done));
    check("halted", 32'(halted), 32'(e.st == 3'd7));
    check("illegal", 32'(illegal), 32'(exp_ill));
    check("cyc_cnt", 32'(cyc_cnt), 32'(exp_cnt[15:0]));
    if (adv && e.pcwre) check("PCSel", 32'(PCSel), 32'(e.pcsel));
    if (adv && e.regwr) check("RegDst", 32'(RegDst), 32'(e.regdst));
    if (e.chk_db) check("DB", 32'(DB), 32'(e.db));
    if (e.chk_alu) check("ALUop", 32'(ALUop), 32'(e.alu));
    @(posedge clk);
    #1;
    if (adv) begin
      if (e.st != 3'd7) exp_cnt++;
      if (e.set_ill) exp_ill = 1'b1;
    end
  endtask

  task automatic play(input int n);
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < StepGap; g++) cycle(seq[i], 1'b0);
      cycle(seq[i], 1'b1);
    end
  endtask

  task automatic run(input string nm, input logic [5:0] o, input logic [5:0] f, input bit z);
    cur = nm; op = o; func = f; zero = z;
    build(o, f, z);
    play(seq.size());
  endtask

  task automatic do_reset();
    cur = "reset";
    nRST = 1'b0;
`ifdef MC_CTRL_STEP_EN
    step = 1'b0;
`endif
    @(negedge clk);
    check("rst_PCWre", 32'(PCWre), 32'd0);
    check("rst_RegWr", 32'(RegWr), 32'd0);
    check("rst_IRWre", 32'(IRWre), 32'd0);
    check("rst_nRD", 32'(nRD), 32'd1);
    check("rst_nWR", 32'(nWR), 32'd1);
    @(posedge clk);
    #1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_cyc_cnt", 32'(cyc_cnt), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    nRST = 1'b1;
    exp_cnt = 0;
    exp_ill = 1'b0;
  endtask

  logic [5:0] ops[12];
  logic [5:0] fns[7];

  initial begin
    logic [5:0] o, f;
    ops = '{6'h00, 6'h08, 6'h0d, 6'h0a, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h02, 6'h03, 6'h3e, 6'h01};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h00, 6'h08};
    @(posedge clk);
    #1;
    do_reset();

    run("add", 6'h00, 6'h20, 1'b0);
    run("lw", 6'h23, 6'h15, 1'b0);
    run("beq_taken", 6'h04, 6'h00, 1'b1);
    run("beq_not", 6'h04, 6'h00, 1'b0);
    run("bne_taken", 6'h05, 6'h00, 1'b0);
    run("jal", 6'h03, 6'h00, 1'b0);
    run("jr", 6'h00, 6'h08, 1'b0);
    run("illegal_op", 6'h3e, 6'h00, 1'b0);
    run("sw_after_ill", 6'h2b, 6'h00, 1'b0);

    // Reset in the first MEM cycle of lw, then in the final MEM cycle of sw
    cur = "lw_abort"; op = 6'h23; func = 6'h00; build(6'h23, 6'h00, 1'b0); play(3);
    do_reset();
    run("after_lw_abort", 6'h00, 6'h22, 1'b0);
    cur = "sw_abort"; op = 6'h2b; func = 6'h00; build(6'h2b, 6'h00, 1'b0);
    play(3 + int'(MemWait));
    do_reset();
    run("after_sw_abort", 6'h0d, 6'h00, 1'b0);

    for (int n = 0; n < 40; n++) begin
      o = ops[$urandom_range(0, 11)];
      f = (o == 6'h00 && $urandom_range(0, 3) != 0) ? fns[$urandom_range(0, 6)]
                                                    : 6'($urandom_range(0, 63));
      run("rand", o, f, 1'($urandom_range(0, 1)));
    end

    run("halt", 6'h3f, 6'h00, 1'b0);
    cur = "halted";
    for (int n = 0; n < 20; n++) cycle(blank(3'd7), 1'b1);
    do_reset();
    run("post_halt_add", 6'h00, 6'h20, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
